// File: rtl/riscv_pkg.sv
// Shared front-end types: machine width, instruction width, reset vector
// and the {pc, instr} record handed from fetch to the datapath.
package riscv_pkg;
  localparam int XLEN = 64;
  localparam int ILEN = 32;
  localparam logic [XLEN-1:0] RESET_PC = '0;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry FIFO of fetched {pc, instr} pairs with flush.
// The head is read straight out of the storage registers.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  fetch_entry_t entry_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output fetch_entry_t head_o,
  output logic [CW-1:0] count_o,
  output logic         empty_o
);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [CW-1:0] cnt_q;
  logic          push_en, pop_en;

  // Flush wins over both push and pop in the same cycle.
  assign push_en = push_i && !flush_i;
  assign pop_en  = pop_i && !flush_i && (cnt_q != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_q + AW'(pop_en);
      wr_q  <= wr_q + AW'(push_en);
      cnt_q <= cnt_q + CW'(push_en) - CW'(pop_en);
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_q] <= entry_i;
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front end: owns the fetch PC, issues 1-cycle-latency
// imem reads under a credit limit, and buffers returned words for the datapath.
module fetch_queue #(
  parameter int XLEN = riscv_pkg::XLEN,
  parameter int DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = riscv_pkg::RESET_PC,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_en,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic [CW-1:0]   fq_count
);
  import riscv_pkg::*;

  localparam int CW1 = CW + 1;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
  logic            inflight_q, inflight_d;
  logic [CW-1:0]   count;
  logic            empty, credit, issue, push, pop;
  fetch_entry_t    head, push_entry;

  // A word may only be requested if the FIFO can absorb it when it returns,
  // so pushes never see a full FIFO.
  assign credit = ({1'b0, count} + CW1'(inflight_q)) < CW1'(DEPTH);
  assign issue  = reset && (redirect || credit);

  assign imem_en   = issue;
  assign imem_addr = (reset && redirect) ? (redirect_pc & ~XLEN'(3)) : fetch_pc_q;

  // The word returning in a redirect cycle belongs to the wrong path.
  assign push       = inflight_q && !redirect;
  assign push_entry = '{pc: inflight_pc_q, instr: imem_rdata};

  assign out_valid = !redirect && !empty;
  assign pop       = out_valid && out_ready;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_pc_d = inflight_pc_q;
    inflight_d    = issue;
    if (issue) begin
      inflight_pc_d = imem_addr;
      fetch_pc_d    = imem_addr + XLEN'(4);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q    <= RESET_PC;
      inflight_pc_q <= RESET_PC;
      inflight_q    <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_pc_q <= inflight_pc_d;
      inflight_q    <= inflight_d;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .entry_i (push_entry),
    .pop_i   (pop),
    .flush_i (redirect),
    .head_o  (head),
    .count_o (count),
    .empty_o (empty)
  );

  assign out_instr = head.instr;
  assign out_pc    = head.pc;
  assign fq_count  = count;

endmodule
